relu_array: RTL

RELU_ARRAY -- requirements
Module: relu_array

---
 rtl/relu_array.sv | 110 +++++++++++
 1 files changed

// File: rtl/relu_array.sv
// relu_array: per-lane ReLU / leaky ReLU / bypass with a registered output beat.
// Optional positive ceiling when RELU_CLAMP_EN is defined.
module relu_array #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES = 4,
  parameter int CELL_AMOUNT = 4,
  parameter int LEAK_SHIFT = 3,
  parameter logic [DATA_WIDTH-1:0] CLAMP_MAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}}
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        index_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0]       out_index,
  output logic                        out_last
);

  localparam int DW = DATA_WIDTH;
  localparam logic [DW-1:0] LAST_IDX = DW'(CELL_AMOUNT - 1);
  localparam logic [DW-1:0] WRAP_ONE =
    (CELL_AMOUNT == 1) ? '0 : DW'(1);

  // A negative ceiling would clamp every positive value to a negative one
  if (CLAMP_MAX[DW-1]) begin : g_bad_clamp
    $error("relu_array: CLAMP_MAX must be non-negative");
  end

  logic                  accept;
  logic [DW-1:0]         cnt;
  logic [DW-1:0]         cnt_nxt;
  logic [DW-1:0]         idx;
  logic [LANES*DW-1:0]   act_data;

  function automatic logic [DW-1:0] act(
    input logic [DW-1:0] v,
    input logic [1:0]    m
  );
    logic signed [DW-1:0] sv;
    logic [DW-1:0]        r;
    sv = v;
    r  = v;
    unique case (1'b1)
      m == 2'b10: r = v;
      m == 2'b01: begin
        if (v[DW-1]) r = sv >>> LEAK_SHIFT;
      end
      default: begin
        if (v[DW-1]) r = '0;
      end
    endcase
`ifdef RELU_CLAMP_EN
    if (m != 2'b10 && !r[DW-1] && r > CLAMP_MAX)
      r = CLAMP_MAX;
`endif
    return r;
  endfunction

  // Upstream may push whenever the output slot is free or draining
  assign in_ready = (!out_valid || out_ready) && rst_n;
  assign accept   = in_valid && in_ready;
  assign idx      = index_clear ? '0 : cnt;

  // Activate every lane independently from the live input and mode
  always_comb begin
    act_data = '0;
    for (int k = 0; k < LANES; k++)
      act_data[k*DW +: DW] = act(in_data[k*DW +: DW], mode);
  end

  // Index counter advance, wrap and clear
  always_comb begin
    cnt_nxt = cnt;
    if (accept)
      cnt_nxt = (idx == LAST_IDX) ? '0 :
                index_clear ? WRAP_ONE : idx + DW'(1);
    else if (index_clear)
      cnt_nxt = '0;
  end

  // Output beat register; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= act_data;
      out_index <= idx;
      out_last  <= (idx == LAST_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sequence counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

endmodule
